// File: rtl/perf_pkg.sv
// Shared types and the counter-update helper for the performance-counter bank.
//   perf_state_t : dump FSM states (IDLE, DUMP)
//   dump_entry_t : one dump entry {idx, value, ovf, last}, sized for the widest
//                  supported configuration; users take the low bits they need
//   cnt_next()   : CNT_WIDTH+1-bit add with carry detection and optional saturate
package perf_pkg;

  localparam int unsigned CNT_W_MAX = 64;
  localparam int unsigned IDX_W_MAX = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DUMP = 1'b1
  } perf_state_t;

  typedef struct packed {
    logic [IDX_W_MAX-1:0] idx;
    logic [CNT_W_MAX-1:0] value;
    logic                 ovf;
    logic                 last;
  } dump_entry_t;

  typedef struct packed {
    logic [CNT_W_MAX-1:0] value;
    logic                 ovf;
  } cnt_res_t;

  // cnt and inc are zero-extended operands of a width-bit counter. The carry is
  // bit 'width' of the sum; since both operands are below 2^width the shifted
  // sum is either 0 or 1.
  function automatic cnt_res_t cnt_next(input logic [CNT_W_MAX-1:0] cnt,
                                        input logic [CNT_W_MAX-1:0] inc,
                                        input int unsigned          width,
                                        input logic                 saturate);
    logic [CNT_W_MAX:0]   sum;
    logic [CNT_W_MAX-1:0] ones;
    cnt_res_t             res;
    sum       = {1'b0, cnt} + {1'b0, inc};
    ones      = {CNT_W_MAX{1'b1}} >> (CNT_W_MAX - width);
    res.ovf   = (sum >> width) != '0;
    res.value = sum[CNT_W_MAX-1:0] & ones;
    if (saturate && res.ovf) res.value = ones;
    return res;
  endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One live event counter with sticky overflow flag.
//   clk, rst     : clock, async active-high reset
//   i_inc_en     : count enable (global enable AND channel mask)
//   i_inc        : increment for this cycle
//   i_clear      : synchronous clear, discards this cycle's increment
//   i_restart    : snapshot taken this cycle, counter restarts at 0
//   o_cnt_upd    : value the counter would hold after this cycle's increment
//   o_ovf_upd    : overflow flag after this cycle's increment
module perf_counter_cell
  import perf_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned INC_WIDTH = 2,
  parameter int unsigned SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_inc_en,
  input  logic [INC_WIDTH-1:0] i_inc,
  input  logic                 i_clear,
  input  logic                 i_restart,
  output logic [CNT_WIDTH-1:0] o_cnt_upd,
  output logic                 o_ovf_upd
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_ovf;
  logic [CNT_W_MAX-1:0] w_cnt_ext;
  logic [CNT_W_MAX-1:0] w_inc_ext;
  cnt_res_t             w_res;
  logic                 w_unused;

  always_comb begin
    w_cnt_ext                = '0;
    w_cnt_ext[CNT_WIDTH-1:0] = r_cnt;
    w_inc_ext                = '0;
    w_inc_ext[INC_WIDTH-1:0] = i_inc;
  end

  assign w_res    = cnt_next(w_cnt_ext, w_inc_ext, CNT_WIDTH, SATURATE != 0);
  assign w_unused = ^w_res.value;

  always_comb begin
    o_cnt_upd = r_cnt;
    o_ovf_upd = r_ovf;
    if (i_inc_en) begin
      o_cnt_upd = w_res.value[CNT_WIDTH-1:0];
      o_ovf_upd = r_ovf | w_res.ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_clear || i_restart) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= o_cnt_upd;
      r_ovf <= o_ovf_upd;
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Performance-counter bank: EVENT_NUM live counters, atomic snapshot-and-clear,
// and a valid/ready stream of the snapshot, one channel per transfer.
//   clk, rst            : clock, async active-high reset
//   en, chan_mask, inc  : global enable, per-channel enable, packed increments
//   clear               : clear live counters and overflow flags
//   snap_req            : snapshot request; snap_drop pulses when rejected
//   busy                : dump in progress
//   dump_valid/ready    : entry handshake
//   dump_idx/value/ovf/last : entry contents
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned EVENT_NUM = 8,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned INC_WIDTH = 2,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned IDX_W     = (EVENT_NUM > 1) ? $clog2(EVENT_NUM) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [EVENT_NUM-1:0]           chan_mask,
  input  logic [EVENT_NUM*INC_WIDTH-1:0] inc,
  input  logic                           clear,
  input  logic                           snap_req,
  output logic                           snap_drop,
  output logic                           busy,
  output logic                           dump_valid,
  input  logic                           dump_ready,
  output logic [IDX_W-1:0]               dump_idx,
  output logic [CNT_WIDTH-1:0]           dump_value,
  output logic                           dump_ovf,
  output logic                           dump_last
);

  perf_state_t          r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [CNT_WIDTH-1:0] r_shadow [EVENT_NUM];
  logic [EVENT_NUM-1:0] r_shadow_ovf;
  dump_entry_t          r_out, w_out_nxt;
  logic                 r_valid;
  logic                 r_drop;

  logic [CNT_WIDTH-1:0] w_cnt_upd [EVENT_NUM];
  logic [EVENT_NUM-1:0] w_ovf_upd;
  logic                 w_snap_acc;
  logic                 w_last;
  logic                 w_unused;

  assign w_snap_acc = (r_state == ST_IDLE) && snap_req && !clear;
  assign w_last     = (r_idx == IDX_W'(EVENT_NUM - 1));

  for (genvar g = 0; g < EVENT_NUM; g++) begin : g_cell
    perf_counter_cell #(
      .CNT_WIDTH(CNT_WIDTH),
      .INC_WIDTH(INC_WIDTH),
      .SATURATE (SATURATE)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .i_inc_en (en & chan_mask[g]),
      .i_inc    (inc[g*INC_WIDTH +: INC_WIDTH]),
      .i_clear  (clear),
      .i_restart(w_snap_acc),
      .o_cnt_upd(w_cnt_upd[g]),
      .o_ovf_upd(w_ovf_upd[g])
    );
  end

  // The output entry is registered one step ahead: it is built from the next
  // index. On snapshot accept the shadow is being written in the same edge, so
  // entry 0 comes straight from the counter update path instead.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      ST_IDLE: if (w_snap_acc) begin
        w_state_nxt = ST_DUMP;
        w_idx_nxt   = '0;
      end
      ST_DUMP: if (dump_ready) begin
        if (w_last) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_out_nxt = '0;
    if (w_state_nxt == ST_DUMP) begin
      w_out_nxt.idx[IDX_W-1:0] = w_idx_nxt;
      w_out_nxt.last           = (w_idx_nxt == IDX_W'(EVENT_NUM - 1));
      if (w_snap_acc) begin
        w_out_nxt.value[CNT_WIDTH-1:0] = w_cnt_upd[0];
        w_out_nxt.ovf                  = w_ovf_upd[0];
      end else begin
        w_out_nxt.value[CNT_WIDTH-1:0] = r_shadow[w_idx_nxt];
        w_out_nxt.ovf                  = r_shadow_ovf[w_idx_nxt];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_out        <= '0;
      r_valid      <= 1'b0;
      r_drop       <= 1'b0;
      r_shadow_ovf <= '0;
      for (int unsigned i = 0; i < EVENT_NUM; i++) r_shadow[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_out   <= w_out_nxt;
      r_valid <= (w_state_nxt == ST_DUMP);
      r_drop  <= snap_req && !w_snap_acc;
      if (w_snap_acc) begin
        r_shadow_ovf <= w_ovf_upd;
        for (int unsigned i = 0; i < EVENT_NUM; i++) r_shadow[i] <= w_cnt_upd[i];
      end
    end
  end

  assign snap_drop  = r_drop;
  assign busy       = r_valid;
  assign dump_valid = r_valid;
  assign dump_idx   = r_out.idx[IDX_W-1:0];
  assign dump_value = r_out.value[CNT_WIDTH-1:0];
  assign dump_ovf   = r_out.ovf;
  assign dump_last  = r_out.last;
  assign w_unused   = ^r_out;

endmodule
